branch_predictor_ras: RTL and testbench

BRANCH_PREDICTOR_RAS -- requirements
Module: branch_predictor_ras

---
 rtl/branch_predictor_ras_if.sv | 29 ++
 rtl/branch_predictor_ras.sv | 125 ++++++++++++
 tb/tb_branch_predictor_ras.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_ras_if.sv
// Predictor bus: pre_IF lookup, EXE resolved-branch update, RAS status.
// master = requester side (fetch/execute), slave = predictor.
interface branch_predictor_ras_if;
  logic        pred_en;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_is_ret;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_is_call;
  logic        upd_is_ret;
  logic        ras_empty;

  modport master (
    output pred_en, pred_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_is_call, upd_is_ret,
    input  pred_hit, pred_taken, pred_target, pred_is_ret, ras_empty
  );

  modport slave (
    input  pred_en, pred_pc, upd_valid, upd_pc, upd_target, upd_taken,
           upd_is_call, upd_is_ret,
    output pred_hit, pred_taken, pred_target, pred_is_ret, ras_empty
  );
endinterface

// File: rtl/branch_predictor_ras.sv
// Direct-mapped flop BTB with 2-bit counters and optional return-address stack.
// Lookup is purely combinational on pre-edge state; updates commit on clk rise.
// Optional feature: define BPU_RAS_EN to build the return-address stack;
// without it return hits predict the stored BTB target and ras_empty is 1.
module branch_predictor_ras #(
  parameter int ENTRIES   = 64,
  parameter int TAG_WD    = 20,
  parameter int RAS_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  branch_predictor_ras_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic              valid;
    logic [TAG_WD-1:0] tag;
    logic              is_ret;
    logic [1:0]        ctr;
    logic [31:0]       target;
  } btb_entry_t;

  btb_entry_t btb [ENTRIES];

  logic [IW-1:0]     p_idx, u_idx;
  logic [TAG_WD-1:0] p_tag, u_tag;
  btb_entry_t        p_ent, u_ent, u_new;
  logic              p_hit, u_hit;
  logic              ras_valid;
  logic [31:0]       ras_top;

  assign p_idx = bus.pred_pc[IW+1:2];
  assign p_tag = bus.pred_pc[IW+2+TAG_WD-1:IW+2];
  assign u_idx = bus.upd_pc[IW+1:2];
  assign u_tag = bus.upd_pc[IW+2+TAG_WD-1:IW+2];
  assign p_ent = btb[p_idx];
  assign u_ent = btb[u_idx];
  assign p_hit = bus.pred_en & p_ent.valid & (p_ent.tag == p_tag);
  assign u_hit = u_ent.valid & (u_ent.tag == u_tag);

  // New entry contents: train counter on hit, allocate on miss; returns pin ctr=11
  always_comb begin
    u_new        = u_ent;
    u_new.valid  = 1'b1;
    u_new.tag    = u_tag;
    u_new.is_ret = bus.upd_is_ret;
    if (u_hit) begin
      if (bus.upd_taken) begin
        u_new.target = bus.upd_target;
        if (u_ent.ctr != 2'b11) u_new.ctr = u_ent.ctr + 2'b01;
      end else if (u_ent.ctr != 2'b00) begin
        u_new.ctr = u_ent.ctr - 2'b01;
      end
    end else begin
      u_new.target = bus.upd_target;
      u_new.ctr    = bus.upd_taken ? 2'b10 : 2'b01;
    end
    if (bus.upd_is_ret) u_new.ctr = 2'b11;
  end

  // BTB storage: async clear, one entry written per resolved branch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) btb[i] <= '0;
    end else if (bus.upd_valid) begin
      btb[u_idx] <= u_new;
    end
  end

`ifdef BPU_RAS_EN
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] CNT_MAX = (RW+1)'(RAS_DEPTH);

  logic [31:0]   ras [RAS_DEPTH];
  logic [RW-1:0] ras_ptr;   // next free slot; top lives at ras_ptr-1
  logic [RW:0]   ras_cnt;
  logic          ras_push, ras_pop;

  // A call wins over a simultaneous return; popping an empty stack is a no-op
  assign ras_push  = bus.upd_valid & bus.upd_is_call;
  assign ras_pop   = bus.upd_valid & bus.upd_is_ret & ~bus.upd_is_call &
                     (ras_cnt != '0);
  assign ras_valid = (ras_cnt != '0);
  assign ras_top   = ras[ras_ptr - RW'(1)];
  assign bus.ras_empty = (ras_cnt == '0);

  // Pointer wraps on overflow so the oldest return address is overwritten
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + RW'(1);
      if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + (RW+1)'(1);
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - RW'(1);
      ras_cnt <= ras_cnt - (RW+1)'(1);
    end
  end

  // Return-address storage; contents are meaningless while count is 0
  always_ff @(posedge clk) begin
    if (resetn && ras_push) ras[ras_ptr] <= bus.upd_pc + 32'd8;
  end
`else
  assign ras_valid     = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_empty = 1'b1;
`endif

  // Prediction outputs, all forced to 0 on a miss
  always_comb begin
    bus.pred_hit    = 1'b0;
    bus.pred_taken  = 1'b0;
    bus.pred_target = '0;
    bus.pred_is_ret = 1'b0;
    if (p_hit) begin
      bus.pred_hit    = 1'b1;
      bus.pred_is_ret = p_ent.is_ret;
      bus.pred_taken  = p_ent.is_ret | p_ent.ctr[1];
      bus.pred_target = (p_ent.is_ret && ras_valid) ? ras_top : p_ent.target;
    end
  end
endmodule

// File: tb/tb_branch_predictor_ras.sv
// Table-driven bench for branch_predictor_ras: each record is a lookup with
// its expected outputs (pre-edge state) plus an update committed on that edge.
module tb_branch_predictor_ras;
`ifdef BPU_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic        pe;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc, utg;
    logic        ut, uc, ur;
    logic        ehit, etk;
    logic [31:0] etg;
    logic        eret, eemp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  vec_t sb[$];

  branch_predictor_ras_if bus ();

  branch_predictor_ras #(.ENTRIES(64), .TAG_WD(20), .RAS_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic em(logic e);
    return RAS ? e : 1'b1;
  endfunction

  function automatic vec_t lk(string nm, logic [31:0] ppc, logic h, logic t,
                              logic [31:0] tg, logic r, logic e);
    vec_t v;
    v.nm = nm; v.pe = 1'b1; v.ppc = ppc;
    v.uv = 1'b0; v.upc = '0; v.utg = '0; v.ut = 1'b0; v.uc = 1'b0; v.ur = 1'b0;
    v.ehit = h; v.etk = t; v.etg = tg; v.eret = r; v.eemp = e;
    return v;
  endfunction

  function automatic vec_t up(vec_t vi, logic [31:0] pc, logic [31:0] tg,
                              logic t, logic c, logic r);
    vec_t v = vi;
    v.uv = 1'b1; v.upc = pc; v.utg = tg; v.ut = t; v.uc = c; v.ur = r;
    return v;
  endfunction

  task automatic set_in(vec_t v);
    bus.pred_en     = v.pe;
    bus.pred_pc     = v.ppc;
    bus.upd_valid   = v.uv;
    bus.upd_pc      = v.upc;
    bus.upd_target  = v.utg;
    bus.upd_taken   = v.ut;
    bus.upd_is_call = v.uc;
    bus.upd_is_ret  = v.ur;
  endtask

  task automatic sample();
    vec_t e;
    logic [35:0] act, exp_v;
    e = sb.pop_front();
    act   = {bus.pred_hit, bus.pred_taken, bus.pred_target, bus.pred_is_ret, bus.ras_empty};
    exp_v = {e.ehit, e.etk, e.etg, e.eret, e.eemp};
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got hit=%b tk=%b tgt=%h ret=%b emp=%b, want hit=%b tk=%b tgt=%h ret=%b emp=%b",
               e.nm, bus.pred_hit, bus.pred_taken, bus.pred_target, bus.pred_is_ret,
               bus.ras_empty, e.ehit, e.etk, e.etg, e.eret, e.eemp);
    end
  endtask

  // Drive now and compare shortly after, without waiting for a clock edge
  task automatic probe(vec_t v);
    set_in(v);
    sb.push_back(v);
    #1 sample();
  endtask

  // Drive at negedge, compare before the posedge that commits the update
  task automatic apply(vec_t v);
    @(negedge clk);
    probe(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // Basic BTB training, saturation, enable gating and aliasing
    tbl.push_back(lk("reset_lookup", 32'hBFC00000, 0, 0, 0, 0, 1));
    tbl.push_back(up(lk("alloc_miss", 32'hBFC00100, 0, 0, 0, 0, 1),
                     32'hBFC00100, 32'hBFC00200, 1, 0, 0));
    tbl.push_back(up(lk("ctr10", 32'hBFC00100, 1, 1, 32'hBFC00200, 0, 1),
                     32'hBFC00100, 32'hDEAD0000, 0, 0, 0));
    tbl.push_back(up(lk("ctr01", 32'hBFC00100, 1, 0, 32'hBFC00200, 0, 1),
                     32'hBFC00100, 32'hDEAD0000, 0, 0, 0));
    tbl.push_back(up(lk("ctr00", 32'hBFC00100, 1, 0, 32'hBFC00200, 0, 1),
                     32'hBFC00100, 32'hDEAD0000, 0, 0, 0));
    tbl.push_back(up(lk("ctr00_sat", 32'hBFC00100, 1, 0, 32'hBFC00200, 0, 1),
                     32'hBFC00100, 32'hBFC00300, 1, 0, 0));
    tbl.push_back(lk("ctr01_inc", 32'hBFC00100, 1, 0, 32'hBFC00300, 0, 1));
    v = lk("pe_off", 32'hBFC00100, 0, 0, 0, 0, 1);
    v.pe = 1'b0;
    tbl.push_back(up(v, 32'h1000, 32'h1100, 1, 0, 0));
    tbl.push_back(up(lk("alias_a_hit", 32'h1000, 1, 1, 32'h1100, 0, 1),
                     32'h1100, 32'h5555, 0, 0, 0));
    tbl.push_back(lk("alias_a_miss", 32'h1000, 0, 0, 0, 0, 1));
    // Return path; return PC 0x3004 avoids sharing index 0 with call 0x2000
    tbl.push_back(up(lk("alias_b_hit", 32'h1100, 1, 0, 32'h5555, 0, 1),
                     32'h3004, 32'h7000, 1, 0, 1));
    tbl.push_back(up(lk("ret_trained", 32'h3004, 1, 1, 32'h7000, 1, 1),
                     32'h2000, 32'h2800, 1, 1, 0));
    tbl.push_back(up(lk("ret_ras_top", 32'h3004, 1, 1, RAS ? 32'h2008 : 32'h7000, 1, em(0)),
                     32'h3004, 32'h7000, 1, 0, 1));
    tbl.push_back(up(lk("call_entry", 32'h2000, 1, 1, 32'h2800, 0, 1),
                     32'h4000, 32'h4400, 1, 1, 1));
    tbl.push_back(up(lk("call_ret_push", 32'h3004, 1, 1, RAS ? 32'h4008 : 32'h7000, 1, em(0)),
                     32'h3004, 32'h7000, 1, 0, 1));
    tbl.push_back(lk("call_ret_entry", 32'h4000, 1, 1, 32'h4400, 1, 1));
    tbl.push_back(up(lk("ras_drained", 32'h3004, 1, 1, 32'h7000, 1, 1),
                     32'h3004, 32'h7000, 1, 0, 1));
    tbl.push_back(lk("empty_pop", 32'h3004, 1, 1, 32'h7000, 1, 1));
    // Overflow: RAS_DEPTH+1 calls, then drain; oldest (0x108) is lost
    for (int i = 0; i < 9; i++)
      tbl.push_back(up(lk($sformatf("push_%0d", i), 32'h3004, 1, 1,
                          (RAS && i > 0) ? 32'(32'h100 * i + 8) : 32'h7000, 1, em(i == 0)),
                       32'(32'h100 * (i + 1)), 32'h0, 1, 1, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(up(lk($sformatf("pop_%0d", k), 32'h3004, 1, 1,
                          RAS ? 32'(32'h908 - 32'h100 * k) : 32'h7000, 1, em(0)),
                       32'h3004, 32'h7000, 1, 0, 1));
    tbl.push_back(up(lk("drained_ovf", 32'h3004, 1, 1, 32'h7000, 1, 1),
                     32'h3004, 32'h7000, 1, 0, 1));
    tbl.push_back(up(lk("underflow_pop", 32'h3004, 1, 1, 32'h7000, 1, 1),
                     32'hA00, 32'h0, 1, 1, 0));
    tbl.push_back(lk("push_after_uf", 32'h3004, 1, 1, RAS ? 32'hA08 : 32'h7000, 1, em(0)));

    // Power-on reset
    v = lk("in_reset", 32'hBFC00000, 0, 0, 0, 0, 1);
    #3 probe(v);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted mid-cycle with an update pending
    @(negedge clk);
    probe(up(lk("pre_reset", 32'h3004, 1, 1, RAS ? 32'hA08 : 32'h7000, 1, em(0)),
             32'h5000, 32'h5100, 1, 0, 0));
    resetn = 1'b0;
    probe(up(lk("async_clear", 32'h3004, 0, 0, 0, 0, 1), 32'h5000, 32'h5100, 1, 0, 0));
    @(posedge clk);
    #1 probe(up(lk("reset_held", 32'h4000, 0, 0, 0, 0, 1), 32'h5000, 32'h5100, 1, 0, 0));
    @(negedge clk);
    resetn = 1'b1;
    probe(up(lk("upd_discarded", 32'h5000, 0, 0, 0, 0, 1), 32'h6000, 32'h6100, 1, 0, 0));
    apply(lk("first_upd_after_rst", 32'h6000, 1, 1, 32'h6100, 0, 1));
    apply(lk("btb_cleared", 32'h1100, 0, 0, 0, 0, 1));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
